// File: rtl/aes_round_seq_if.sv
// aes_round_seq_if: CPU-side handshake and datapath control bundle of the AES round sequencer.
interface aes_round_seq_if;
    logic       start;
    logic       abort;
    logic       out_ready;
    logic       busy;
    logic       out_valid;
    logic       sel_init;
    logic       state_we;
    logic       key_we;
    logic       final_round;
    logic [3:0] round;
    logic [7:0] rcon;
    modport master (
        output start, abort, out_ready,
        input  busy, out_valid, sel_init, state_we, key_we, final_round, round, rcon
    );
    modport slave (
        input  start, abort, out_ready,
        output busy, out_valid, sel_init, state_we, key_we, final_round, round, rcon
    );
endinterface

// File: rtl/aes_round_seq.sv
// aes_round_seq: Moore sequencer for an iterative AES-128 round datapath (INIT, rounds 1-9, final round, result handshake).
module aes_round_seq #(
    parameter int ROUND_CYCLES = 1
) (
    input logic          clk,
    input logic          rst_n,
    aes_round_seq_if.slave bus
);
    localparam int SW = ROUND_CYCLES > 1 ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(ROUND_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

    state_t        state, nstate;
    logic [SW-1:0] sub, nsub;
    logic [3:0]    rnd, nrnd;
    logic          nrounding;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        nstate = state;
        nsub   = sub;
        nrnd   = rnd;
        case (state)
            IDLE: if (bus.start && !bus.abort) begin
                nstate = INIT;
                nsub   = '0;
                nrnd   = 4'd0;
            end
            INIT: begin
                nstate = ROUND;
                nsub   = '0;
                nrnd   = 4'd1;
            end
            ROUND, FINAL: if (sub == SUB_LAST) begin
                nsub   = '0;
                nstate = state == FINAL ? DONE : (rnd == 4'd9 ? FINAL : ROUND);
                nrnd   = state == FINAL ? 4'd0 : rnd + 4'd1;
            end else begin
                nsub = sub + SW'(1);
            end
            DONE: if (bus.out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
        // abort wins everywhere except IDLE, so no write enable is ever registered for the cancelled job
        if (bus.abort && state != IDLE) begin
            nstate = IDLE;
            nsub   = '0;
            nrnd   = 4'd0;
        end
        nrounding = nstate == ROUND || nstate == FINAL;
    end

    // outputs are registered from the next-state decode so they align with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sub             <= '0;
            rnd             <= 4'd0;
            bus.busy        <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.sel_init    <= 1'b0;
            bus.state_we    <= 1'b0;
            bus.key_we      <= 1'b0;
            bus.final_round <= 1'b0;
            bus.round       <= 4'd0;
            bus.rcon        <= 8'h00;
        end else begin
            state           <= nstate;
            sub             <= nsub;
            rnd             <= nrnd;
            bus.busy        <= nstate != IDLE;
            bus.out_valid   <= nstate == DONE;
            bus.sel_init    <= nstate == INIT;
            bus.state_we    <= nstate == INIT || (nrounding && nsub == SUB_LAST);
            bus.key_we      <= nstate == INIT || (nrounding && nsub == SUB_LAST);
            bus.final_round <= nstate == FINAL;
            bus.round       <= nrounding ? nrnd : 4'd0;
            bus.rcon        <= nrounding ? rcon_of(nrnd) : 8'h00;
        end
    end
endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Moore-style sequencer for the iterative AES-128 encryption datapath attached to the Core.
- Accepts a start request from the CPU side and drives the load-mux select and register write enables of the shared round datapath.
- Sequences initial AddRoundKey, rounds 1-9 and the final round 10 (no MixColumns), and supplies round number and Rcon to the key expansion.
- Presents the result with a valid/ready handshake.

Parameters:
- ROUND_CYCLES, 1, cycles per round (>=1); write enables fire only in the last cycle of each round, to allow a multicycle round datapath.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to encrypt; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE next edge
- out_ready  input  1  consumer accepts result
- busy  output  1  high in every state except IDLE
- out_valid  output  1  result (state register) valid
- sel_init  output  1  datapath mux selects plaintext^cipherkey
- state_we  output  1  state register write enable
- key_we  output  1  round-key register write enable
- final_round  output  1  datapath bypasses MixColumns
- round  output  4  current round number 0..10
- rcon  output  8  round constant for the key expansion

Behaviour:
- Reset: asynchronous, active-low. Forces FSM=IDLE, sub-cycle counter=0, round counter=0. All outputs 0: busy, out_valid, sel_init, state_we, key_we, final_round, round=0, rcon=8'h00.
- All outputs decode from registered state only; no combinational path from any input to any output.
- IDLE:
  - start=1 -> INIT.
  - Otherwise stay in IDLE.
- INIT (1 cycle):
  - sel_init=1, state_we=1, key_we=1, round=0, rcon=8'h00.
  - Next state is ROUND with round counter=1.
- ROUND (rounds 1..9):
  - round=counter; rcon=Rcon(counter).
  - Sub-counter runs 0..ROUND_CYCLES-1.
  - state_we and key_we are asserted only when sub-counter=ROUND_CYCLES-1. On that cycle the round counter increments and the sub-counter clears.
  - Leaving round 9 goes to FINAL.
- FINAL (round 10):
  - Same timing as ROUND, with final_round=1, round=10, rcon=8'h36.
  - On its last sub-cycle the FSM goes to DONE.
- DONE:
  - out_valid=1, busy=1, round=0, rcon=8'h00, all write enables 0.
  - out_ready=1 -> IDLE. Otherwise hold; out_valid stays high and stable.
- Rcon table for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36 (hex). Implement as a case table or as xtime with 0x1B reduction. rcon=8'h00 outside ROUND/FINAL.
- Latency with start sampled at edge k:
  - INIT occupies cycle k+1.
  - Round r occupies cycles k+2+(r-1)*ROUND_CYCLES .. k+1+r*ROUND_CYCLES.
  - out_valid rises at k+2+10*ROUND_CYCLES. For ROUND_CYCLES=1 that is k+12.
- Exactly 11 state_we pulses and 11 key_we pulses per encryption: INIT plus 10 rounds.
- start while busy (any non-IDLE state) is ignored; no queueing.
- start and out_ready both high in DONE: return to IDLE only. A new start is taken on a later IDLE cycle, so there is a minimum one IDLE cycle between jobs.
- abort:
  - Highest priority in every non-IDLE state. Next edge forces IDLE and clears both counters.
  - Write enables are suppressed in the cycle abort is sampled only if they would be asserted in the next state. The current-cycle Moore outputs still reflect the current state.
  - abort in IDLE has no effect and takes priority over start.
- rst_n low mid-operation: immediate return to reset values, regardless of clk.
- Round counter never exceeds 10; sub-counter never reaches ROUND_CYCLES.

Test Plan:
- Basic, ROUND_CYCLES=1:
  - Stimulus: reset release, start pulse at edge k, out_ready held 1.
  - Required: sel_init only at k+1; state_we high k+1..k+11 (11 cycles); round 1..10 with rcon 01,02,04,08,10,20,40,80,1B,36 at k+2..k+11; final_round only at k+11; out_valid exactly at k+12; IDLE at k+13.
- Multicycle, ROUND_CYCLES=3:
  - Required: state_we pulses at k+1, then every 3rd cycle; out_valid at k+32; each round value held 3 cycles.
- Back-pressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid rises.
  - Required: out_valid and busy held, no write enables; out_valid drops the cycle after out_ready=1.
- Start while busy:
  - Stimulus: start pulses during round 4 and during DONE with out_ready=1.
  - Required: no restart; rcon sequence unchanged; second job begins only after start seen in IDLE.
- Abort:
  - Stimulus: abort asserted during round 6.
  - Required: next cycle busy=0, round=0, rcon=0, no further state_we; following start produces the full 11-pulse sequence from round 1.
- Asynchronous reset:
  - Stimulus: rst_n driven low between clock edges in round 8.
  - Required: all outputs 0 immediately; after release, FSM idles until start.
